// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared widths, port index type and priority helper for the ingress queue
package arb_pkg;

  localparam int DEF_NUM_PORTS = 4;
  localparam int DEF_DEPTH     = 4;
  localparam int PORT_W        = $clog2(DEF_NUM_PORTS);
  localparam int OCC_W         = $clog2(DEF_DEPTH) + 1;

  typedef logic [PORT_W-1:0] port_idx_t;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic int unsigned lowest_set_idx(input logic [31:0] vec);
    lowest_set_idx = 0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) lowest_set_idx = i;
    end
  endfunction

endpackage

// File: rtl/arb_port_fifo.sv
// rtl/arb_port_fifo.sv - per-port synchronous FIFO with occupancy-derived full/empty
module arb_port_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   occ
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]     occ_q, occ_d;
  logic              do_push, do_pop;

  // A full FIFO refuses a push even when the same cycle pops it.
  assign full    = (occ_q == OW'(DEPTH));
  assign empty   = (occ_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];
  assign occ     = occ_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q + OW'(do_push) - OW'(do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

endmodule

// File: rtl/arb_ingress_queue.sv
// rtl/arb_ingress_queue.sv - per-port ingress FIFOs feeding a granted, registered output stage
module arb_ingress_queue
  import arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_PORTS-1:0]                    in_valid,
  output logic [NUM_PORTS-1:0]                    in_ready,
  input  logic [NUM_PORTS*DATA_W-1:0]             in_data,
  output logic [NUM_PORTS-1:0]                    req_o,
  input  logic [NUM_PORTS-1:0]                    gnt_i,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [DATA_W-1:0]                       out_data,
  output logic [$clog2(NUM_PORTS)-1:0]            out_port,
  output logic [NUM_PORTS*($clog2(DEPTH)+1)-1:0]  occ_o,
  output logic                                    gnt_err_o
);

  localparam int PW = $clog2(NUM_PORTS);
  localparam int OW = $clog2(DEPTH) + 1;

  logic [NUM_PORTS-1:0] full, empty, pop, sel;
  logic [DATA_W-1:0]    head [NUM_PORTS];
  logic [PW-1:0]        sel_idx;
  logic                 load_en;

  logic                 out_valid_q, out_valid_d;
  logic [DATA_W-1:0]    out_data_q, out_data_d;
  logic [PW-1:0]        out_port_q, out_port_d;
  logic                 gnt_err_q, gnt_err_d;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    arb_port_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (in_valid[g]),
      .push_data (in_data[g*DATA_W +: DATA_W]),
      .pop       (pop[g]),
      .head      (head[g]),
      .full      (full[g]),
      .empty     (empty[g]),
      .occ       (occ_o[g*OW +: OW])
    );
  end

  // Requests only go out when the output register can take a word this cycle.
  assign in_ready = ~full & {NUM_PORTS{~reset}};
  assign load_en  = ~out_valid_q | out_ready;
  assign req_o    = ~empty & {NUM_PORTS{load_en}};
  assign sel      = gnt_i & req_o;
  assign sel_idx  = PW'(lowest_set_idx(32'(sel)));

  always_comb begin
    pop          = '0;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_port_d   = out_port_q;
    gnt_err_d    = (sel & (sel - NUM_PORTS'(1))) != '0;
    if (sel != '0) begin
      pop[sel_idx] = 1'b1;
      out_valid_d  = 1'b1;
      out_data_d   = head[sel_idx];
      out_port_d   = sel_idx;
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_port_q  <= '0;
      gnt_err_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_port_q  <= out_port_d;
      gnt_err_q   <= gnt_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_port  = out_port_q;
  assign gnt_err_o = gnt_err_q;

endmodule

// File: tb/tb_arb_ingress_queue.sv
// tb/tb_arb_ingress_queue.sv - scoreboard bench with queue-based port model and round-robin arbiter
module tb_arb_ingress_queue;
  import arb_pkg::*;

  localparam int NP = 4;
  localparam int DW = 8;
  localparam int DP = 4;
  localparam int OW = 3;

  typedef struct packed {
    port_idx_t   port;
    logic [7:0]  data;
  } item_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [NP-1:0]     in_valid, in_ready, req_o, gnt_i;
  logic [NP*DW-1:0]  in_data;
  logic              out_valid, out_ready, gnt_err_o;
  logic [DW-1:0]     out_data;
  logic [1:0]        out_port;
  logic [NP*OW-1:0]  occ_o;

  item_t       sb[$];
  logic [7:0]  mq[NP][$];
  bit          mvalid = 1'b0;
  bit          exp_err = 1'b0;
  int          rr_last = NP - 1;
  int          n_cmp = 0;
  int          n_bad = 0;

  arb_ingress_queue #(.NUM_PORTS(NP), .DATA_W(DW), .DEPTH(DP)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .req_o     (req_o),
    .gnt_i     (gnt_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_port  (out_port),
    .occ_o     (occ_o),
    .gnt_err_o (gnt_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every accepted output word must be the oldest outstanding grant.
  always @(negedge clk) begin : monitor
    item_t e;
    if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_word: got port %0d data %0h expected none", out_port, out_data);
      end else begin
        e = sb.pop_front();
        chk("out_data", 32'(out_data), 32'(e.data));
        chk("out_port", 32'(out_port), 32'(e.port));
      end
    end
  end

  function automatic logic [NP-1:0] rr_pick(input logic [NP-1:0] r);
    rr_pick = '0;
    for (int off = 1; off <= NP; off++) begin
      int j;
      j = (rr_last + off) % NP;
      if (r[j] && rr_pick == '0) rr_pick[j] = 1'b1;
    end
  endfunction

  // gmode: 0 = no grant, 1 = round-robin arbiter, 2 = forced gnt value
  task automatic step(input logic [NP-1:0] iv, input logic [NP*DW-1:0] idata,
                      input logic ordy, input int gmode, input logic [NP-1:0] gforce);
    logic [NP-1:0] mreq, g, s, acc;
    int k;
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(mvalid));
    chk("gnt_err", 32'(gnt_err_o), 32'(exp_err));
    for (int i = 0; i < NP; i++) begin
      chk($sformatf("occ%0d", i), 32'(occ_o[i*OW +: OW]), 32'(mq[i].size()));
      chk($sformatf("in_ready%0d", i), 32'(in_ready[i]), 32'(mq[i].size() < DP));
    end
    in_valid  = iv;
    in_data   = idata;
    out_ready = ordy;
    gnt_i     = '0;
    #1;
    for (int i = 0; i < NP; i++) mreq[i] = (mq[i].size() > 0) && (!mvalid || ordy);
    chk("req_o", 32'(req_o), 32'(mreq));
    g = (gmode == 2) ? gforce : ((gmode == 1) ? rr_pick(mreq) : '0);
    gnt_i = g;
    s = g & mreq;
    exp_err = ($countones(s) > 1);
    for (int i = 0; i < NP; i++) acc[i] = iv[i] && (mq[i].size() < DP);
    if (s != '0) begin
      k = 0;
      for (int i = NP - 1; i >= 0; i--) if (s[i]) k = i;
      sb.push_back('{port: port_idx_t'(k), data: mq[k].pop_front()});
      mvalid = 1'b1;
      if (gmode == 1) rr_last = k;
    end else if (ordy) begin
      mvalid = 1'b0;
    end
    for (int i = 0; i < NP; i++) if (acc[i]) mq[i].push_back(idata[i*DW +: DW]);
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int c = 0; c < n; c++) step('0, '0, ordy, 1, '0);
  endtask

  task automatic check_reset_values();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_port", 32'(out_port), 32'd0);
    chk("rst_occ", 32'(occ_o), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_req", 32'(req_o), 32'd0);
    chk("rst_gnt_err", 32'(gnt_err_o), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_reset_values();
    sb.delete();
    for (int i = 0; i < NP; i++) mq[i].delete();
    mvalid   = 1'b0;
    exp_err  = 1'b0;
    rr_last  = NP - 1;
    in_valid = '0;
    gnt_i    = '0;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
  endtask

  initial begin
    int guard;
    reset = 1'b1; in_valid = '0; in_data = '0; gnt_i = '0; out_ready = 1'b1;
    #2;
    check_reset_values();
    #20;
    reset = 1'b0;

    // single word on port 2 travels to the output two cycles later
    step(4'b0100, 32'h00A1_0000, 1'b1, 1, '0);
    idle(4, 1'b1);

    // port 0 fills; fifth push must be refused
    for (int j = 0; j < 5; j++) step(4'b0001, 32'(8'h30 + j), 1'b1, 0, '0);
    idle(8, 1'b1);

    // all ports loaded twice: round-robin drains back to back
    rr_last = NP - 1;
    step(4'b1111, 32'h1312_1110, 1'b1, 0, '0);
    step(4'b1111, 32'h2322_2120, 1'b1, 0, '0);
    idle(10, 1'b1);

    // downstream stall holds the output and blocks requests
    step(4'b1111, 32'h4443_4241, 1'b1, 0, '0);
    step('0, '0, 1'b1, 1, '0);
    for (int j = 0; j < 4; j++) step('0, '0, 1'b0, 1, '0);
    idle(8, 1'b1);

    // multi-bit grant: lowest requester served, error flagged
    step(4'b0110, 32'h0055_6600, 1'b1, 0, '0);
    step('0, '0, 1'b1, 2, 4'b0110);
    step('0, '0, 1'b1, 0, '0);
    idle(4, 1'b1);

    // reset with buffered words and a stalled output word
    step(4'b1011, 32'h7700_8899, 1'b1, 0, '0);
    step('0, '0, 1'b0, 1, '0);
    step('0, '0, 1'b0, 1, '0);
    do_reset();
    idle(4, 1'b1);

    // randomized traffic
    for (int c = 0; c < 400; c++)
      step(NP'($urandom), 32'($urandom), ($urandom_range(3) != 0), 1, '0);

    guard = 0;
    while ((sb.size() != 0 || mvalid || mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size() != 0)
           && guard < 100) begin
      idle(1, 1'b1);
      guard++;
    end
    idle(2, 1'b1);
    chk("drain_scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
